square_pwm_gen: RTL

Parametrised square/PWM generator for the function generator datapath. Drives a WIDTH-bit sample stream alternating between programmable high and low amplitude levels, with programmable period and duty cycle. Runtime reconfiguration goes through a valid/ready port and takes effect only at period boundaries, so the output is glitch-free. Output feeds the same waveform mux/DAC path as the other wave sources.

---
 rtl/square_pwm_pkg.sv | 11 +
 rtl/square_pwm_if.sv | 24 ++
 rtl/square_pwm_cfg_shadow.sv | 58 +++++
 rtl/square_pwm_gen.sv | 73 +++++++
 4 files changed

// File: rtl/square_pwm_pkg.sv
// square_pwm_pkg: shared FSM state type and reset-default constants for the square/PWM generator.
package square_pwm_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_WIDTH_C  = 8;
    localparam int DEF_CNT_W_C  = 16;
    localparam int DEF_PERIOD_C = 512;
    localparam int DEF_HIGH_C   = 256;

endpackage

// File: rtl/square_pwm_if.sv
// square_pwm_if: valid/ready configuration port carrying period, high length and both amplitude levels.
interface square_pwm_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic [WIDTH-1:0] cfg_amp_hi;
    logic [WIDTH-1:0] cfg_amp_lo;

    modport master (
        output cfg_valid, cfg_period, cfg_high, cfg_amp_hi, cfg_amp_lo,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_high, cfg_amp_hi, cfg_amp_lo,
        output cfg_ready
    );

endinterface

// File: rtl/square_pwm_cfg_shadow.sv
// square_pwm_cfg_shadow: pending/active config banks with handshake; pending is clamped into active on apply_i.
module square_pwm_cfg_shadow #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 512,
    parameter int DEF_HIGH   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    square_pwm_if.slave      cfg,
    output logic [CNT_W-1:0] act_period_o,
    output logic [CNT_W-1:0] nxt_high_o,
    output logic [WIDTH-1:0] nxt_amp_hi_o,
    output logic [WIDTH-1:0] nxt_amp_lo_o
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [WIDTH-1:0] amp_hi;
        logic [WIDTH-1:0] amp_lo;
    } cfg_t;

    cfg_t             pend_q, pend_d, act_q, act_d, clamp;
    logic             full_q, full_d, fire;
    logic [CNT_W-1:0] cp;

    assign cfg.cfg_ready = !full_q;

    // nxt_* is the config the sample written on this edge must use
    always_comb begin
        fire   = cfg.cfg_valid && !full_q;
        cp     = (pend_q.period < CNT_W'(2)) ? CNT_W'(2) : pend_q.period;
        clamp  = {cp, (pend_q.high > cp) ? cp : pend_q.high, pend_q.amp_hi, pend_q.amp_lo};
        act_d  = (apply_i && full_q) ? clamp : act_q;
        pend_d = fire ? {cfg.cfg_period, cfg.cfg_high, cfg.cfg_amp_hi, cfg.cfg_amp_lo} : pend_q;
        full_d = fire || (full_q && !apply_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= {CNT_W'(DEF_PERIOD), CNT_W'(DEF_HIGH), {WIDTH{1'b1}}, WIDTH'(0)};
            pend_q <= '0;
            full_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            full_q <= full_d;
        end
    end

    assign act_period_o = act_q.period;
    assign nxt_high_o   = act_d.high;
    assign nxt_amp_hi_o = act_d.amp_hi;
    assign nxt_amp_lo_o = act_d.amp_lo;

endmodule

// File: rtl/square_pwm_gen.sv
// square_pwm_gen: glitch-free square/PWM sample generator; define SQUARE_PWM_SYNC_EN to add the sync_in forced-wrap input.
module square_pwm_gen
    import square_pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 512,
    parameter int DEF_HIGH   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SQUARE_PWM_SYNC_EN
    input  logic             sync_in,
`endif
    square_pwm_if.slave      cfg,
    output logic [WIDTH-1:0] wave,
    output logic             phase_high,
    output logic             period_tick
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, act_period, nxt_high;
    logic [WIDTH-1:0] wave_q, nxt_amp_hi, nxt_amp_lo;
    logic             ph_q, tick_q, wrap, apply, hi_d;

    square_pwm_cfg_shadow #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .DEF_HIGH(DEF_HIGH)
    ) u_shadow (
        .clk(clk), .rst(rst), .apply_i(apply), .cfg(cfg),
        .act_period_o(act_period), .nxt_high_o(nxt_high),
        .nxt_amp_hi_o(nxt_amp_hi), .nxt_amp_lo_o(nxt_amp_lo)
    );

    always_comb begin
`ifdef SQUARE_PWM_SYNC_EN
        wrap  = (state_q == RUN) && ((cnt_q == act_period - CNT_W'(1)) || sync_in);
`else
        wrap  = (state_q == RUN) && (cnt_q == act_period - CNT_W'(1));
`endif
        apply = (state_q == IDLE) || wrap;
        cnt_d = (state_q == IDLE || !en || wrap) ? '0 : cnt_q + CNT_W'(1);
        hi_d  = cnt_d < nxt_high;
    end

    // period >= 2 after clamping, so cnt_d == 0 only on a wrap or a restart
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wave_q  <= '0;
            ph_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= en && (cnt_d == '0);
            if (en) begin
                state_q <= RUN;
                wave_q  <= hi_d ? nxt_amp_hi : nxt_amp_lo;
                ph_q    <= hi_d;
            end else if (state_q == RUN) begin
                state_q <= IDLE;
                wave_q  <= nxt_amp_lo;
                ph_q    <= 1'b0;
            end
        end
    end

    assign wave        = wave_q;
    assign phase_high  = ph_q;
    assign period_tick = tick_q;

endmodule
